// File: rtl/fp_mult_pipe.sv
// rtl/fp_mult_pipe.sv - three-stage pipelined IEEE-754 multiplier (product, normalise, round) with valid/ready
// Optional sideband tag travelling with each operation: FP_MULT_PIPE_TAG_EN.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [2:0]             rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   z,
`ifdef FP_MULT_PIPE_TAG_EN
    input  logic [TAG_W-1:0]       in_tag,
    output logic [TAG_W-1:0]       out_tag,
`endif
    output logic [7:0]             status
);

    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int EW2 = EXP_W + 2;
    localparam int PW  = 2 * MAN_W + 2;
    localparam logic [EW2-1:0]        BIAS     = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] EXP_SAT  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RUP = 3'd2;
    localparam logic [2:0] RM_RDN = 3'd3;
    localparam logic [2:0] RM_RNA = 3'd4;

    typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

    // Flow control: each stage advances when empty or when its successor advances.
    logic s1_valid_q, s2_valid_q, s3_valid_q;
    logic s1_adv, s2_adv, s3_adv;

    assign s3_adv    = !s3_valid_q || out_ready;
    assign s2_adv    = !s2_valid_q || s3_adv;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s3_valid_q;

    // Stage 1: unpack, classify, exponent sum and mantissa product.
    logic                 a_sgn, b_sgn;
    logic [EXP_W-1:0]     a_exp, b_exp;
    logic [MAN_W-1:0]     a_frac, b_frac;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    cls_e                 s1_cls_d, s1_cls_q;
    logic                 s1_sgn_d, s1_sgn_q;
    logic [EW2-1:0]       s1_exp_d, s1_exp_q;
    logic [PW-1:0]        s1_prod_d, s1_prod_q;
    logic [2:0]           s1_rnd_d, s1_rnd_q;

    assign {a_sgn, a_exp, a_frac} = a;
    assign {b_sgn, b_exp, b_frac} = b;

    // A zero exponent field covers both true zeros and flushed subnormals.
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (&a_exp) && (a_frac == '0);
    assign b_inf  = (&b_exp) && (b_frac == '0);
    assign a_nan  = (&a_exp) && (a_frac != '0);
    assign b_nan  = (&b_exp) && (b_frac != '0);

    always_comb begin
        s1_cls_d = CLS_NUM;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_cls_d = CLS_NAN;
        end else if (a_inf || b_inf) begin
            s1_cls_d = CLS_INF;
        end else if (a_zero || b_zero) begin
            s1_cls_d = CLS_ZERO;
        end
    end

    assign s1_sgn_d  = a_sgn ^ b_sgn;
    assign s1_exp_d  = {2'b00, a_exp} + {2'b00, b_exp} - BIAS;
    assign s1_prod_d = PW'({1'b1, a_frac}) * PW'({1'b1, b_frac});
    assign s1_rnd_d  = (rnd > RM_RNA) ? RM_RNE : rnd;

    // Stage 2: normalise the product in [1,4) to [1,2), form guard and sticky.
    logic                 prod_msb;
    logic [MAN_W:0]       s2_mant_d, s2_mant_q;
    logic                 s2_guard_d, s2_guard_q;
    logic                 s2_sticky_d, s2_sticky_q;
    logic [EW2-1:0]       s2_exp_d, s2_exp_q;
    cls_e                 s2_cls_q;
    logic                 s2_sgn_q;
    logic [2:0]           s2_rnd_q;

    assign prod_msb = s1_prod_q[PW-1];

    always_comb begin
        s2_mant_d   = s1_prod_q[PW-2 -: MAN_W+1];
        s2_guard_d  = s1_prod_q[MAN_W-1];
        s2_sticky_d = |s1_prod_q[MAN_W-2:0];
        if (prod_msb) begin
            s2_mant_d   = s1_prod_q[PW-1 -: MAN_W+1];
            s2_guard_d  = s1_prod_q[MAN_W];
            s2_sticky_d = |s1_prod_q[MAN_W-1:0];
        end
    end

    assign s2_exp_d = s1_exp_q + EW2'(prod_msb);

    // Stage 3: round, handle exponent range, pack result and flags.
    logic                 round_inc;
    logic [MAN_W+1:0]     mant_rnd;
    logic                 mant_carry;
    logic [MAN_W-1:0]     frac_rnd;
    logic signed [EW2-1:0] exp_rnd;
    logic                 ovf, unf, ovf_to_inf;
    logic                 f_inexact, f_huge, f_tiny, f_nan, f_inf, f_zero;
    logic [W-1:0]         z_d, z_q;
    logic [7:0]           status_d, status_q;

    always_comb begin
        round_inc = 1'b0;
        case (s2_rnd_q)
            RM_RNE:  round_inc = s2_guard_q && (s2_sticky_q || s2_mant_q[0]);
            RM_RTZ:  round_inc = 1'b0;
            RM_RUP:  round_inc = (s2_guard_q || s2_sticky_q) && !s2_sgn_q;
            RM_RDN:  round_inc = (s2_guard_q || s2_sticky_q) && s2_sgn_q;
            RM_RNA:  round_inc = s2_guard_q;
            default: round_inc = 1'b0;
        endcase
    end

    assign mant_rnd   = {1'b0, s2_mant_q} + (MAN_W+2)'(round_inc);
    assign mant_carry = mant_rnd[MAN_W+1];
    assign frac_rnd   = mant_carry ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
    assign exp_rnd    = s2_exp_q + EW2'(mant_carry);
    assign ovf        = (exp_rnd >= EXP_SAT);
    assign unf        = (exp_rnd <= EXP_ZERO);

    // Directed modes only saturate to infinity when rounding away from zero.
    assign ovf_to_inf = (s2_rnd_q == RM_RNE) || (s2_rnd_q == RM_RNA) ||
                        ((s2_rnd_q == RM_RUP) && !s2_sgn_q) ||
                        ((s2_rnd_q == RM_RDN) && s2_sgn_q);

    always_comb begin
        z_d       = {s2_sgn_q, exp_rnd[EXP_W-1:0], frac_rnd};
        f_inexact = s2_guard_q || s2_sticky_q;
        f_huge    = 1'b0;
        f_tiny    = 1'b0;
        f_nan     = 1'b0;
        f_inf     = 1'b0;
        f_zero    = 1'b0;
        case (s2_cls_q)
            CLS_NAN: begin
                z_d       = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                f_inexact = 1'b0;
                f_nan     = 1'b1;
            end
            CLS_INF: begin
                z_d       = {s2_sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                f_inexact = 1'b0;
                f_inf     = 1'b1;
            end
            CLS_ZERO: begin
                z_d       = {s2_sgn_q, {(W-1){1'b0}}};
                f_inexact = 1'b0;
                f_zero    = 1'b1;
            end
            default: begin
                if (ovf) begin
                    f_huge    = 1'b1;
                    f_inexact = 1'b1;
                    if (ovf_to_inf) begin
                        z_d   = {s2_sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        f_inf = 1'b1;
                    end else begin
                        z_d = {s2_sgn_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                    end
                end else if (unf) begin
                    z_d       = {s2_sgn_q, {(W-1){1'b0}}};
                    f_tiny    = 1'b1;
                    f_inexact = 1'b1;
                    f_zero    = 1'b1;
                end
            end
        endcase
        status_d = {2'b00, f_inexact, f_huge, f_tiny, f_nan, f_inf, f_zero};
    end

    assign z      = z_q;
    assign status = status_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s3_adv) s3_valid_q <= s2_valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_cls_q    <= CLS_NUM;
            s1_sgn_q    <= 1'b0;
            s1_exp_q    <= '0;
            s1_prod_q   <= '0;
            s1_rnd_q    <= '0;
            s2_mant_q   <= '0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_exp_q    <= '0;
            s2_cls_q    <= CLS_NUM;
            s2_sgn_q    <= 1'b0;
            s2_rnd_q    <= '0;
            z_q         <= '0;
            status_q    <= '0;
        end else begin
            if (s1_adv && in_valid) begin
                s1_cls_q  <= s1_cls_d;
                s1_sgn_q  <= s1_sgn_d;
                s1_exp_q  <= s1_exp_d;
                s1_prod_q <= s1_prod_d;
                s1_rnd_q  <= s1_rnd_d;
            end
            if (s2_adv && s1_valid_q) begin
                s2_mant_q   <= s2_mant_d;
                s2_guard_q  <= s2_guard_d;
                s2_sticky_q <= s2_sticky_d;
                s2_exp_q    <= s2_exp_d;
                s2_cls_q    <= s1_cls_q;
                s2_sgn_q    <= s1_sgn_q;
                s2_rnd_q    <= s1_rnd_q;
            end
            if (s3_adv && s2_valid_q) begin
                z_q      <= z_d;
                status_q <= status_d;
            end
        end
    end

`ifdef FP_MULT_PIPE_TAG_EN
    logic [TAG_W-1:0] s1_tag_q, s2_tag_q, out_tag_q;

    assign out_tag = out_tag_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_tag_q  <= '0;
            s2_tag_q  <= '0;
            out_tag_q <= '0;
        end else begin
            if (s1_adv && in_valid)   s1_tag_q  <= in_tag;
            if (s2_adv && s1_valid_q) s2_tag_q  <= s1_tag_q;
            if (s3_adv && s2_valid_q) out_tag_q <= s2_tag_q;
        end
    end
`endif

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb/tb_fp_mult_pipe.sv - self-checking bench for fp_mult_pipe (float32 defaults)
module tb_fp_mult_pipe;

    localparam int TAG_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  rnd = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] z;
    logic [7:0]  status;
`ifdef FP_MULT_PIPE_TAG_EN
    logic [TAG_W-1:0] in_tag = '0;
    logic [TAG_W-1:0] out_tag;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_out = 0;
    bit rand_done = 0;
    logic [39:0] sb_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rnd;
        logic [31:0] z;
        logic [7:0]  st;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
`ifdef FP_MULT_PIPE_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .status    (status)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded remainder with one half.
    function automatic logic [39:0] ref_mul(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] rm_in);
        logic [2:0] rm;
        logic s, za, zb, ia, ib, na, nb, up;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, q, rem, half;
        rm = (rm_in > 3'd4) ? 3'd0 : rm_in;
        s  = av[31] ^ bv[31];
        ea = int'(av[30:23]);
        eb = int'(bv[30:23]);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (av[22:0] == 0);
        ib = (eb == 255) && (bv[22:0] == 0);
        na = (ea == 255) && (av[22:0] != 0);
        nb = (eb == 255) && (bv[22:0] != 0);
        if (na || nb || (ia && zb) || (ib && za)) return {32'h7FC00000, 8'h04};
        if (ia || ib) return {s, 8'hFF, 23'h0, 8'h02};
        if (za || zb) return {s, 31'h0, 8'h01};
        ma = (64'd1 << 23) | 64'(av[22:0]);
        mb = (64'd1 << 23) | 64'(bv[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            sh = 24;
            e  = e + 1;
        end else begin
            sh = 23;
        end
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        case (rm)
            3'd0:    up = (rem > half) || ((rem == half) && q[0]);
            3'd1:    up = 1'b0;
            3'd2:    up = (rem != 0) && !s;
            3'd3:    up = (rem != 0) && s;
            default: up = (rem >= half);
        endcase
        q = q + 64'(up);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) begin
            if (rm == 0 || rm == 4 || (rm == 2 && !s) || (rm == 3 && s))
                return {s, 8'hFF, 23'h0, 8'h32};
            return {s, 8'hFE, 23'h7FFFFF, 8'h30};
        end
        if (e <= 0) return {s, 31'h0, 8'h29};
        return {s, 8'(e), q[22:0], 2'b00, (rem != 0), 5'b00000};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0]  e;
        logic [22:0] f;
        int k;
        k = $urandom_range(0, 15);
        f = 23'($urandom);
        if (k < 9)        e = 8'($urandom_range(107, 147));
        else if (k < 11)  e = 8'($urandom_range(190, 254));
        else if (k < 13)  e = 8'($urandom_range(1, 64));
        else if (k == 13) e = 8'd0;
        else if (k == 14) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) f = '0;
        end else begin
            e = 8'($urandom_range(120, 134));
            f = 23'h7FFFFF ^ 23'($urandom_range(0, 7));
        end
        return {1'($urandom), e, f};
    endfunction

    // Scoreboard: sampled on the falling edge, where handshakes are stable.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                logic [39:0] e;
                n_out++;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_z", z, e[39:8]);
                    check("sb_status", status, e[7:0]);
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(ref_mul(a, b, rnd));
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] rv);
        logic acc;
        in_valid = 1'b1;
        a = av;
        b = bv;
        rnd = rv;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int lat;
        send(v.a, v.b, v.rnd);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_z"}, z, v.z);
        check({name, "_status"}, status, v.st);
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base_acc, base_out, cnt;

        vecs.push_back('{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h20});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 8'h20});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800003, 8'h20});
        vecs.push_back('{32'hBF800001, 32'h3F800001, 3'd3, 32'hBF800003, 8'h20});
        vecs.push_back('{32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800002, 8'h20});
        vecs.push_back('{32'h3FC00000, 32'h3F800003, 3'd0, 32'h3FC00004, 8'h20});
        vecs.push_back('{32'h3FC00000, 32'h3F800003, 3'd4, 32'h3FC00005, 8'h20});
        vecs.push_back('{32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 8'h32});
        vecs.push_back('{32'h7F000000, 32'h40000000, 3'd1, 32'h7F7FFFFF, 8'h30});
        vecs.push_back('{32'hFF000000, 32'h40000000, 3'd2, 32'hFF7FFFFF, 8'h30});
        vecs.push_back('{32'h7F000000, 32'h40000000, 3'd2, 32'h7F800000, 8'h32});
        vecs.push_back('{32'h7F000000, 32'h40000000, 3'd3, 32'h7F7FFFFF, 8'h30});
        vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 3'd0, 32'h7F7FFFFF, 8'h00});
        vecs.push_back('{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04});
        vecs.push_back('{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h04});
        vecs.push_back('{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 8'h02});
        vecs.push_back('{32'h00000000, 32'hC0000000, 3'd0, 32'h80000000, 8'h01});
        vecs.push_back('{32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 8'h01});
        vecs.push_back('{32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 8'h00});
        vecs.push_back('{32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 8'h29});
        vecs.push_back('{32'h20000000, 32'h1F800000, 3'd0, 32'h00000000, 8'h29});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_z", z, 0);
        check("reset_status", status, 0);
        rst = 1'b0;
        tick();
        check("reset_in_ready", in_ready, 1);

        // Directed vectors, one at a time
        out_ready = 1'b1;
        foreach (vecs[i]) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: six back-to-back operations against a stalled consumer
        out_ready = 1'b0;
        base_acc = n_acc;
        base_out = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(32'h3F800000 + 32'(i << 20), 32'h40000000 + 32'(i), 3'd0);
            end
            begin
                repeat (5) tick();
                check("bp_in_ready_low", in_ready, 0);
                check("bp_held_count", n_acc - base_acc, 3);
                out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    check($sformatf("bp_no_gap%0d", i), out_valid, 1);
                    tick();
                end
            end
        join
        check("bp_result_count", n_out - base_out, 6);
        check("bp_drained", sb_q.size(), 0);

        // Randomised traffic with random consumer stalls
        base_out = n_out;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(rand_op(), rand_op(), 3'($urandom_range(0, 7)));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
        check("rand_drained", sb_q.size(), 0);
        check("rand_result_count", n_out - base_out, 400);

        // Reset with two operations in flight
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = 32'h40000000;
        b = 32'h40000000;
        rnd = 3'd0;
        tick();
        a = 32'h40400000;
        tick();
        in_valid = 1'b0;
        tick();
        check("rst_pre_out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", out_valid, 0);
        check("rst_async_z", z, 0);
        check("rst_async_status", status, 0);
        tick();
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (out_valid) cnt++;
        end
        check("rst_no_stale_result", cnt, 0);
        check("rst_in_ready", in_ready, 1);
        run_vec("post_rst", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
Pipelined IEEE-754 binary floating-point multiplier, parametrised in exponent and mantissa width, with rounding mode selected per operation. It is the next generation of the combinational single-precision multiplier: three register stages (product, normalise, round/exception) with valid/ready flow control on both sides. It sits between the FP operand issue logic and the result writeback, and returns the same 8-bit status flag vector per result.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1
MAN_W, 23, stored fraction width; word width W = 1+EXP_W+MAN_W
TAG_W, 4, width of the sideband tag (used only with FP_MULT_PIPE_TAG_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  operands a, b and rnd are valid
in_ready  out  1  block accepts an operation this cycle
a  in  W  operand A
b  in  W  operand B
rnd  in  3  rounding mode: 0 near-even, 1 toward zero, 2 toward +inf, 3 toward -inf, 4 near-away; 5-7 treated as 0
out_valid  out  1  z and status are valid
out_ready  in  1  consumer accepts the result
z  out  W  product a*b
status  out  8  {2'b00, inexact, huge, tiny, nan, inf, zero}

Behaviour:
- Reset (asynchronous, rst=1): all stage valid bits clear. out_valid=0, z=0, status=0. in_ready=1 from the first cycle after reset deassertion. An operation in flight when reset asserts is discarded.
- Transfer rules: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- Pipeline: S1 unpacks operands, computes sign, exponent sum (EXP_W+2 bits, signed, bias subtracted) and the (2*MAN_W+2)-bit mantissa product. S2 normalises (1-bit shift on MSB) and forms guard and sticky. S3 rounds, detects exceptions and registers z/status.
- Latency: 3 cycles with no stall. Sustained throughput is one operation per cycle.
- Flow control: stage k loads when it is empty or when stage k+1 loads / the output transfers. in_ready = !s1_valid || s1 advances, so in_ready is combinational from out_ready through the stages. With out_ready held low, exactly 3 operations are held and in_ready drops. Results keep issue order; none are dropped or duplicated.
- Simultaneous accept and emit in the same cycle is legal at full occupancy.
- Subnormal inputs are flushed to signed zero before S1.
- Special cases (resolved in S1, carried in flags):
  - NaN operand, or 0*inf: z is the canonical qNaN (sign 0, exponent all-ones, fraction MSB 1, rest 0); nan=1.
  - inf*nonzero: ±inf; inf=1.
  - zero*finite: ±0; zero=1.
- Rounding: the increment decision uses guard, sticky, LSB, sign and the rnd value. A mantissa carry-out renormalises and increments the exponent. inexact = guard|sticky.
- Overflow: rounded biased exponent >= 2^EXP_W-1 sets huge=1 and inexact=1. Result by mode:
  - near-even / near-away: ±inf (inf=1).
  - toward zero: ±max finite.
  - toward +inf: +inf for positive, -max finite for negative.
  - toward -inf: mirror of toward +inf.
- Underflow: rounded biased exponent <= 0 flushes to ±0 with tiny=1, inexact=1, zero=1.
- Flag rules: status[7:6] are always 0. All flags are registered together with z.

Optional Feature:
FP_MULT_PIPE_TAG_EN:
- Defined: adds ports in_tag (in, TAG_W) and out_tag (out, TAG_W). The tag is captured with the operands and travels through all three stages, so out_tag always matches its own result. out_tag resets to 0.
- Undefined: no tag ports and no tag registers; all other behaviour is identical.

Test Plan:
- Basic, float32 defaults: a=3FC00000, b=40000000, rnd=0, out_ready=1 -> out_valid exactly 3 cycles later; z=40400000, status=00.
- Rounding: a=b=3F800001, rnd=0 -> z=3F800002, status=20. Same operands with rnd=1 -> z=3F800002, status=20.
- Overflow: a=7F000000, b=40000000. rnd=0 -> z=7F800000, status=32. rnd=1 -> z=7F7FFFFF, status=30. a sign flipped with rnd=2 -> z=FF7FFFFF.
- Specials:
  - 7F800000 * 00000000 -> z=7FC00000, status=04.
  - 00800000 * 00800000 -> z=00000000, status=29.
- Backpressure: issue 6 back-to-back operations with out_ready low for 5 cycles -> in_ready=0 after 3 are accepted. After release, all 6 results appear in order, with no gaps when out_ready=1.
- Reset mid-operation: assert rst while 2 operations are in flight -> out_valid=0 immediately. No stale result emerges after rst deasserts.
